mem_lsu: RTL and testbench

Load/store unit that acts as the requester side of the data-memory port. It turns pipeline load/store requests (RV32I funct3 encodings) into word-granular accesses on the memory's single port: 32-bit address, word write-enable `mem_rw`, asynchronous read. Byte and halfword stores become a read-modify-write sequence, because the memory writes whole words only. Loads are byte/halfword extracted and sign- or zero-extended. The block sits between the execute stage and data memory, and its request handshake stalls the pipeline.

---
 rtl/mem_lsu_pkg.sv | 43 ++++
 rtl/mem_lsu_if.sv | 35 +++
 rtl/mem_lsu_align.sv | 44 ++++
 rtl/mem_lsu.sv | 110 +++++++++++
 tb/tb_mem_lsu.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared funct3 encodings, FSM state type and error check for mem_lsu
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam int MEM_DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Covers misalignment and illegal encodings, including unsigned stores.
  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo,
                                          input logic       we);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = addr_lo[0];
      F3_W:        err = (addr_lo != 2'b00);
      default:     err = 1'b1;
    endcase
    if (we && funct3[2]) err = 1'b1;
    return err;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_if.sv
// ============================================================================
// mem_lsu_if : pipeline request/response and data-memory port of the LSU
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_lsu_if;

  logic                                   req_valid;
  logic                                   req_ready;
  logic                                   req_we;
  logic [2:0]                             req_funct3;
  logic [31:0]                            req_addr;
  logic [lsu_pkg::MEM_DATA_WIDTH-1:0]     req_wdata;
  logic                                   resp_valid;
  logic [lsu_pkg::MEM_DATA_WIDTH-1:0]     resp_rdata;
  logic                                   resp_err;
  logic [31:0]                            mem_addr;
  logic [lsu_pkg::MEM_DATA_WIDTH-1:0]     mem_wdata;
  logic                                   mem_rw;
  logic [lsu_pkg::MEM_DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
  );

endinterface

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// ============================================================================
// lsu_align : combinational load extract and store merge on a memory word
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [MEM_DATA_WIDTH-1:0] word_i,
  input  logic [1:0]                off_i,
  input  logic [2:0]                funct3_i,
  input  logic [MEM_DATA_WIDTH-1:0] wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] load_o,
  output logic [MEM_DATA_WIDTH-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{(MEM_DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{(MEM_DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   load_o = {{(MEM_DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   load_o = {{(MEM_DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_o = word_i;
    endcase

    // Untouched lanes keep the word just read from memory.
    merge_o = word_i;
    case (funct3_i)
      F3_B:    merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// mem_lsu : load/store unit driving a word-write, async-read data memory port
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lsu
  import lsu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  mem_lsu_if.slave bus
);

  lsu_state_t                state_q;
  logic                      we_q;
  logic [2:0]                funct3_q;
  logic [31:0]               addr_q;
  logic [MEM_DATA_WIDTH-1:0] wdata_q;
  logic [MEM_DATA_WIDTH-1:0] wbuf_q;
  logic [MEM_DATA_WIDTH-1:0] rdata_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic                      rw_q;
  logic [MEM_DATA_WIDTH-1:0] load_data;
  logic [MEM_DATA_WIDTH-1:0] merge_data;

  lsu_align u_align (
    .word_i   (bus.mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (funct3_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      wbuf_q       <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
            if (lsu_misaligned(bus.req_funct3, bus.req_addr[1:0], bus.req_we)) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= ST_RESP;
            end else if (!bus.req_we) begin
              state_q <= ST_LOAD;
            end else if (bus.req_funct3 == F3_W) begin
              wbuf_q  <= bus.req_wdata;
              rw_q    <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_LOAD: begin
          rdata_q      <= load_data;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_READ: begin
          wbuf_q  <= merge_data;
          rw_q    <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          rw_q         <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          rdata_q      <= '0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the strobes so an aborted sequence never writes or responds.
  assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q && !reset;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata  = wbuf_q;
  assign bus.mem_rw     = rw_q && we_q && !reset;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// tb_mem_lsu : vector table, corner sequences and random ops against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;

  logic clk;
  logic reset;
  logic preload;
  int   total;
  int   bad;
  int   n_rw;
  int   n_resp;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] resp_q  [$];

  mem_lsu_if ifc ();

  mem_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h8899AABB;
    if (i == 24) return 32'h11223344;
    return (32'(i) * 32'h01030507) ^ 32'hA5A50000;
  endfunction

  assign ifc.mem_rdata = mem[ifc.mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (ifc.mem_rw) begin
      mem[ifc.mem_addr[7:2]] <= ifc.mem_wdata;
    end
    if (ifc.mem_rw) n_rw <= n_rw + 1;
    if (ifc.resp_valid) begin
      n_resp <= n_resp + 1;
      resp_q.push_back(ifc.resp_rdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  // Reference model: byte-mask arithmetic over a word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                       output int e_lat, output logic [31:0] e_ww);
    int          off;
    int          size;
    logic [31:0] w, mask, v;
    off   = int'(a[1:0]);
    w     = ref_mem[a[7:2]];
    e_rd  = 32'h0;
    e_ww  = 32'h0;
    e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
            (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      if (size == 1) begin
        v = (w >> (8 * off)) & 32'hFF;
        e_rd = (!f3[2] && v >= 32'd128) ? v - 32'd256 : v;
      end else if (size == 2) begin
        v = (w >> (8 * off)) & 32'hFFFF;
        e_rd = (!f3[2] && v >= 32'd32768) ? v - 32'd65536 : v;
      end else begin
        e_rd = w;
      end
    end else begin
      e_lat = (size == 4) ? 2 : 3;
      mask  = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1) << (8 * off);
      e_ww  = (w & ~mask) | ((wd << (8 * off)) & mask);
      ref_mem[a[7:2]] = e_ww;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic g_err, output logic [31:0] g_rd,
                        output int g_lat, output int g_nwr, output logic [31:0] g_ww,
                        output int g_wc, output logic [31:0] g_ma);
    int guard;
    g_err = 1'b0; g_rd = 32'h0; g_lat = 0; g_nwr = 0; g_ww = 32'h0; g_wc = 0; g_ma = 32'h0;
    ifc.req_valid  = 1'b1;
    ifc.req_we     = we;
    ifc.req_funct3 = f3;
    ifc.req_addr   = a;
    ifc.req_wdata  = wd;
    guard = 0;
    while (!ifc.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    g_ma = ifc.mem_addr;
    for (int k = 1; k <= 8; k++) begin
      if (ifc.mem_rw) begin
        g_nwr++;
        g_ww = ifc.mem_wdata;
        g_wc = k;
      end
      if (ifc.resp_valid) begin
        g_lat = k;
        g_err = ifc.resp_err;
        g_rd  = ifc.resp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rd, input int e_lat, input logic [31:0] e_ww);
    logic        g_err;
    logic [31:0] g_rd, g_ww, g_ma;
    int          g_lat, g_nwr, g_wc;
    do_req(we, f3, a, wd, g_err, g_rd, g_lat, g_nwr, g_ww, g_wc, g_ma);
    chk({nm, " latency"}, 32'(g_lat), 32'(e_lat));
    chk({nm, " err"}, 32'(g_err), 32'(e_err));
    chk({nm, " rdata"}, g_rd, e_rd);
    chk({nm, " writes"}, 32'(g_nwr), (we && !e_err) ? 32'd1 : 32'd0);
    chk({nm, " mem_addr"}, g_ma, {a[31:2], 2'b00});
    if (we && !e_err) begin
      chk({nm, " wdata"}, g_ww, e_ww);
      chk({nm, " write cycle"}, 32'(g_wc), 32'(e_lat - 1));
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] wword;
  } vec_t;

  vec_t tbl [13];

  initial begin : main
    logic        m_err;
    logic [31:0] m_rd, m_ww;
    int          m_lat;
    logic [31:0] exp_b2b [4];
    int          acc [4];
    int          idx, cyc, nready, rbase, rw0, rs0;
    logic        was_ready;
    logic [31:0] b_addr [4];
    logic [2:0]  b_f3 [4];

    total = 0; bad = 0; n_rw = 0; n_resp = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    tbl[0]  = '{1'b0, 3'b000, 32'h41, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 32'h0};
    tbl[1]  = '{1'b0, 3'b100, 32'h41, 32'h0,        1'b0, 32'h000000AA, 2, 32'h0};
    tbl[2]  = '{1'b0, 3'b001, 32'h42, 32'h0,        1'b0, 32'hFFFF8899, 2, 32'h0};
    tbl[3]  = '{1'b0, 3'b101, 32'h42, 32'h0,        1'b0, 32'h00008899, 2, 32'h0};
    tbl[4]  = '{1'b1, 3'b000, 32'h43, 32'h5A,       1'b0, 32'h0,        3, 32'h5A99AABB};
    tbl[5]  = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'h5A99AABB, 2, 32'h0};
    tbl[6]  = '{1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 1'b0, 32'h0,        2, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 3'b001, 32'h82, 32'hABCD1234, 1'b0, 32'h0,        3, 32'h1234BEEF};
    tbl[8]  = '{1'b0, 3'b010, 32'h80, 32'h0,        1'b0, 32'h1234BEEF, 2, 32'h0};
    tbl[9]  = '{1'b0, 3'b010, 32'h41, 32'h0,        1'b1, 32'h0,        1, 32'h0};
    tbl[10] = '{1'b1, 3'b001, 32'h83, 32'h1111,     1'b1, 32'h0,        1, 32'h0};
    tbl[11] = '{1'b0, 3'b011, 32'h40, 32'h0,        1'b1, 32'h0,        1, 32'h0};
    tbl[12] = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'h5A99AABB, 2, 32'h0};

    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_funct3 = 3'b000;
    ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
    reset = 1'b1; preload = 1'b1;

    // Reset state
    @(posedge clk); #1;
    preload = 1'b0;
    chk("reset req_ready", 32'(ifc.req_ready), 32'd0);
    chk("reset resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("reset resp_err", 32'(ifc.resp_err), 32'd0);
    chk("reset resp_rdata", ifc.resp_rdata, 32'd0);
    chk("reset mem_rw", 32'(ifc.mem_rw), 32'd0);
    chk("reset mem_addr", ifc.mem_addr, 32'd0);
    chk("reset mem_wdata", ifc.mem_wdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready after reset", 32'(ifc.req_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_err, m_rd, m_lat, m_ww);
      apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
            tbl[i].err, tbl[i].rdata, tbl[i].lat, tbl[i].wword);
    end

    // Reset during the READ cycle of a byte store
    ifc.req_valid = 1'b1; ifc.req_we = 1'b1; ifc.req_funct3 = 3'b000;
    ifc.req_addr = 32'h63; ifc.req_wdata = 32'h77;
    for (int g = 0; g < 20 && !ifc.req_ready; g++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    rw0 = n_rw; rs0 = n_resp;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort ready after reset", 32'(ifc.req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort writes", 32'(n_rw - rw0), 32'd0);
    chk("abort responses", 32'(n_resp - rs0), 32'd0);
    chk("abort memory", mem[24], ref_mem[24]);

    // Back-to-back loads with req_valid held high
    b_addr[0] = 32'h40; b_f3[0] = 3'b010;
    b_addr[1] = 32'h41; b_f3[1] = 3'b100;
    b_addr[2] = 32'h42; b_f3[2] = 3'b101;
    b_addr[3] = 32'h80; b_f3[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      model(1'b0, b_f3[i], b_addr[i], 32'h0, m_err, m_rd, m_lat, m_ww);
      exp_b2b[i] = m_rd;
      acc[i] = -100;
    end
    rbase = resp_q.size();
    idx = 0; cyc = 0; nready = 0;
    ifc.req_valid = 1'b1; ifc.req_we = 1'b0;
    ifc.req_funct3 = b_f3[0]; ifc.req_addr = b_addr[0];
    while (idx < 4 && cyc < 40) begin
      was_ready = ifc.req_ready;
      if (was_ready) acc[idx] = cyc;
      else if (idx >= 1) nready++;
      @(posedge clk); #1;
      cyc++;
      if (was_ready) begin
        idx++;
        if (idx < 4) begin
          ifc.req_funct3 = b_f3[idx];
          ifc.req_addr   = b_addr[idx];
        end else begin
          ifc.req_valid = 1'b0;
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b accepted", 32'(idx), 32'd4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b spacing %0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
    chk("b2b not-ready cycles", 32'(nready), 32'd6);
    chk("b2b responses", 32'(resp_q.size() - rbase), 32'd4);
    for (int i = 0; i < 4; i++)
      if (rbase + i < resp_q.size())
        chk($sformatf("b2b rdata %0d", i), resp_q[rbase + i], exp_b2b[i]);

    // Random operations against the model
    for (int n = 0; n < 200; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a, r_wd;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = 32'($urandom_range(0, 255));
      r_wd = $urandom;
      model(r_we, r_f3, r_a, r_wd, m_err, m_rd, m_lat, m_ww);
      apply($sformatf("rnd%0d", n), r_we, r_f3, r_a, r_wd, m_err, m_rd, m_lat, m_ww);
    end

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++)
      chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
